lane_block_encoder: RTL and testbench
=====================================

# lane_block_encoder

Transmit-side block-forming stage directly downstream of the two-lane distributer. It accepts one byte per clock per lane while `enable_enc` is high and packs eight consecutive bytes per lane into a 66-bit block with a 2-bit sync header. It optionally scrambles the payload, then presents both lanes' blocks in parallel with a one-cycle valid strobe to the serializer stage.

## Interface
Parameters:
- `SEED`, default 58'h3FF_FFFF_FFFF_FFFF: scrambler reset/reinit state.
- `HDR_DATA`, default 2'b10: sync header for data blocks.
- `HDR_OS`, default 2'b01: sync header for ordered-set blocks.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `enable_enc`  in  1: byte-accept qualifier from the distributer; low = idle/flush.
- `d_sel`  in  4: payload type of the current byte; 4'h8 = data, anything else = ordered set.
- `lane_0_tx_in`  in  8: lane 0 byte.
- `lane_1_tx_in`  in  8: lane 1 byte.
- `lane_0_block`  out  66: lane 0 block; [1:0] header, [9:2] byte0 … [65:58] byte7.
- `lane_1_block`  out  66: lane 1 block, same layout.
- `block_valid`  out  1: one-cycle pulse; both blocks are valid.
- `hdr_mismatch`  out  1: one-cycle pulse with `block_valid`; `d_sel` class changed inside the block.

## Operation
- Byte counter `byte_cnt` (3 bits) is shared by both lanes. On each edge with `enable_enc`=1, the byte from each lane is written to slot `byte_cnt`, and the counter increments, wrapping 7→0.
- The header class is latched from `d_sel` on the slot-0 byte: data if `d_sel`==4'h8, else OS.
- If any of slots 1–7 has a class differing from the latched class, a sticky mismatch flag is set. The latched header still wins.
- Slot-7 accept: the assembled payload plus header is loaded into the `lane_x_block` output registers, `block_valid` is set to 1, and `hdr_mismatch` is set to the sticky flag OR the slot-7 mismatch. Then the sticky flag clears and a new block starts at slot 0 on the next byte.
- `block_valid` and `hdr_mismatch` are 0 on every other cycle. `lane_x_block` holds its value between strobes.
- `enable_enc`=0 on a clock edge:
  - `byte_cnt` is set to 0 and any partial block is discarded (no strobe).
  - The sticky flag clears.
  - Scrambler state reloads `SEED`.
  - `block_valid`=0. `lane_x_block` holds.
- If `enable_enc` drops on the same edge a slot-7 byte would be accepted, that byte is not accepted and no strobe occurs.
- Headers are never scrambled.

## Timing
- Reset values: `lane_0_block`=0, `lane_1_block`=0, `block_valid`=0, `hdr_mismatch`=0, `byte_cnt`=0, sticky flag=0, scrambler state=`SEED`.
- Latency: the slot-7 byte is accepted at edge N; the block is visible and `block_valid`=1 during cycle N..N+1 (registered, one edge).
- Throughput: one block per 8 enabled cycles per lane. Strobes are at least 8 cycles apart.
- There is no backpressure. The downstream stage must consume on the strobe.
- Asserting reset mid-block clears everything immediately and asynchronously. Accumulation resumes at slot 0 after reset is released.

## Configuration
- `LANE_SCRAMBLER_EN` defined:
  - Each lane has an independent self-synchronous scrambler, x^58+x^39+1, with 58-bit state `s`.
  - Scrambling is bit-serial, LSB first, 8 steps per byte per cycle: out = in ^ s[38] ^ s[57]; s = {s[56:0], out}.
  - Scrambled bytes are stored in the block.
  - State advances only on accepted bytes.
- `LANE_SCRAMBLER_EN` undefined: payload bytes are stored unmodified, no scrambler state exists, and `SEED` is unused.

## Structure
- Shared package `usb4_tx_pkg`:
  - `D_SEL_DATA`=4'h8.
  - Header constants.
  - `BLOCK_W`=66, `BYTES_PER_BLOCK`=8.
  - Scrambler tap constants 38/57.
- Sub-module `lane_scrambler`: one instance per lane. Inputs are byte, advance, reinit; output is scrambled byte. It is combinational per byte with registered state. It is instantiated only under `LANE_SCRAMBLER_EN`.
- The top module contains the counter, header latch, mismatch logic and output registers.

## Test plan
- Macro off, reset, then `enable_enc`=1 with `d_sel`=8:
  - Stimulus: lane 0 bytes 00..07, lane 1 bytes 10..17.
  - Response: after the 8th edge, `block_valid`=1 for exactly one cycle; `lane_0_block`=66'h{07060504030201 00, 2'b10}; `lane_1_block` has bytes 10..17 with header 2'b10.
- Macro off, `d_sel`=4'h2 for all 8 bytes: header = 2'b01 and `hdr_mismatch`=0.
- `d_sel`=8 on bytes 0–4 and 4'h2 on bytes 5–7: header 2'b10 and `hdr_mismatch`=1 with the strobe.
- `enable_enc` dropped after 5 bytes, then raised for 8 new bytes: no strobe for the partial block; the next strobe carries only the 8 new bytes in slots 0–7.
- Reset asserted after 3 bytes: all outputs 0 immediately. After release, 8 bytes give one strobe at the 8th edge.
- Macro on, `SEED` default:
  - Stimulus: 16 bytes of 00 on both lanes.
  - Response: the payloads of both strobes match a bit-level reference model of x^58+x^39+1; both lanes are identical; headers are unscrambled; reinit after `enable_enc` low reproduces the first block exactly.

Source files
------------

// File: rtl/usb4_tx_pkg.sv
// ============================================================================
// usb4_tx_pkg : shared constants and types for the USB4 transmit block path
// Rev 1.0
// ============================================================================
`default_nettype none

package usb4_tx_pkg;

  localparam logic [3:0] D_SEL_DATA      = 4'h8;
  localparam logic [1:0] HDR_DATA_DEF    = 2'b10;
  localparam logic [1:0] HDR_OS_DEF      = 2'b01;
  localparam int         BLOCK_W         = 66;
  localparam int         BYTES_PER_BLOCK = 8;
  localparam int         SCR_W           = 58;
  localparam int         SCR_TAP_A       = 38;
  localparam int         SCR_TAP_B       = 57;

  typedef enum logic {
    CLS_OS   = 1'b0,
    CLS_DATA = 1'b1
  } hdr_class_e;

  function automatic hdr_class_e class_of(input logic [3:0] d_sel);
    return (d_sel == D_SEL_DATA) ? CLS_DATA : CLS_OS;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_scrambler.sv
// ============================================================================
// lane_scrambler : per-lane self-synchronous x^58+x^39+1 byte scrambler
// Rev 1.0
// ============================================================================
`default_nettype none

module lane_scrambler
  import usb4_tx_pkg::*;
#(
  parameter logic [SCR_W-1:0] SEED = 58'h3FF_FFFF_FFFF_FFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       advance_i,
  input  logic       reinit_i,
  output logic [7:0] byte_o
);

  logic [SCR_W-1:0] state_q;
  logic [SCR_W-1:0] state_d;
  logic [SCR_W-1:0] steps;

  // Eight serial steps, LSB first; each output bit feeds the shift register.
  always_comb begin
    steps  = state_q;
    byte_o = 8'h00;
    for (int i = 0; i < 8; i++) begin
      byte_o[i] = byte_i[i] ^ steps[SCR_TAP_A] ^ steps[SCR_TAP_B];
      steps     = {steps[SCR_W-2:0], byte_o[i]};
    end
    state_d = state_q;
    if (reinit_i) begin
      state_d = SEED;
    end else if (advance_i) begin
      state_d = steps;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lane_block_encoder.sv
// ============================================================================
// lane_block_encoder : packs 8 bytes per lane into 66-bit sync-header blocks
// Optional payload scrambling when LANE_SCRAMBLER_EN is defined.   Rev 1.0
// ============================================================================
`default_nettype none

module lane_block_encoder
  import usb4_tx_pkg::*;
#(
  parameter logic [SCR_W-1:0] SEED     = 58'h3FF_FFFF_FFFF_FFFF,
  parameter logic [1:0]       HDR_DATA = HDR_DATA_DEF,
  parameter logic [1:0]       HDR_OS   = HDR_OS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_enc,
  input  logic [3:0]         d_sel,
  input  logic [7:0]         lane_0_tx_in,
  input  logic [7:0]         lane_1_tx_in,
  output logic [BLOCK_W-1:0] lane_0_block,
  output logic [BLOCK_W-1:0] lane_1_block,
  output logic               block_valid,
  output logic               hdr_mismatch
);

  logic [2:0]                             byte_cnt_q, byte_cnt_d;
  hdr_class_e                             hdr_cls_q, hdr_cls_d;
  logic                                   sticky_q, sticky_d;
  logic [BYTES_PER_BLOCK-2:0][7:0]        pay0_q, pay0_d, pay1_q, pay1_d;
  logic [BLOCK_W-1:0]                     blk0_q, blk0_d, blk1_q, blk1_d;
  logic                                   valid_q, valid_d, mis_q, mis_d;
  logic [7:0]                             byte0, byte1;
  hdr_class_e                             cur_cls;
  logic [1:0]                             hdr;

`ifdef LANE_SCRAMBLER_EN
  lane_scrambler #(.SEED(SEED)) u_scr0 (
    .clk(clk), .rst(rst), .byte_i(lane_0_tx_in),
    .advance_i(enable_enc), .reinit_i(!enable_enc), .byte_o(byte0)
  );
  lane_scrambler #(.SEED(SEED)) u_scr1 (
    .clk(clk), .rst(rst), .byte_i(lane_1_tx_in),
    .advance_i(enable_enc), .reinit_i(!enable_enc), .byte_o(byte1)
  );
`else
  logic unused_seed;
  assign unused_seed = ^SEED;
  assign byte0       = lane_0_tx_in;
  assign byte1       = lane_1_tx_in;
`endif

  assign cur_cls = class_of(d_sel);
  assign hdr     = (hdr_cls_q == CLS_DATA) ? HDR_DATA : HDR_OS;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    hdr_cls_d  = hdr_cls_q;
    sticky_d   = sticky_q;
    pay0_d     = pay0_q;
    pay1_d     = pay1_q;
    blk0_d     = blk0_q;
    blk1_d     = blk1_q;
    valid_d    = 1'b0;
    mis_d      = 1'b0;
    if (!enable_enc) begin
      byte_cnt_d = 3'd0;
      sticky_d   = 1'b0;
    end else begin
      byte_cnt_d = byte_cnt_q + 3'd1;
      if (byte_cnt_q == 3'd7) begin
        // Last byte goes straight to the output; it never touches the slot store.
        blk0_d   = {byte0, pay0_q, hdr};
        blk1_d   = {byte1, pay1_q, hdr};
        valid_d  = 1'b1;
        mis_d    = sticky_q | (cur_cls != hdr_cls_q);
        sticky_d = 1'b0;
      end else begin
        pay0_d[byte_cnt_q] = byte0;
        pay1_d[byte_cnt_q] = byte1;
        if (byte_cnt_q == 3'd0) begin
          hdr_cls_d = cur_cls;
        end else begin
          sticky_d = sticky_q | (cur_cls != hdr_cls_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_q <= 3'd0;
      hdr_cls_q  <= CLS_OS;
      sticky_q   <= 1'b0;
      pay0_q     <= '0;
      pay1_q     <= '0;
      blk0_q     <= '0;
      blk1_q     <= '0;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      hdr_cls_q  <= hdr_cls_d;
      sticky_q   <= sticky_d;
      pay0_q     <= pay0_d;
      pay1_q     <= pay1_d;
      blk0_q     <= blk0_d;
      blk1_q     <= blk1_d;
      valid_q    <= valid_d;
      mis_q      <= mis_d;
    end
  end

  assign lane_0_block = blk0_q;
  assign lane_1_block = blk1_q;
  assign block_valid  = valid_q;
  assign hdr_mismatch = mis_q;

endmodule

`default_nettype wire

// File: tb/tb_lane_block_encoder.sv
// ============================================================================
// tb_lane_block_encoder : directed + random stimulus against a queue-based model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lane_block_encoder;

  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_enc = 1'b0;
  logic [3:0]  d_sel = 4'h0;
  logic [7:0]  lane_0_tx_in = 8'h00;
  logic [7:0]  lane_1_tx_in = 8'h00;
  logic [65:0] lane_0_block, lane_1_block;
  logic        block_valid, hdr_mismatch;

  lane_block_encoder dut (
    .clk(clk), .rst(rst), .enable_enc(enable_enc), .d_sel(d_sel),
    .lane_0_tx_in(lane_0_tx_in), .lane_1_tx_in(lane_1_tx_in),
    .lane_0_block(lane_0_block), .lane_1_block(lane_1_block),
    .block_valid(block_valid), .hdr_mismatch(hdr_mismatch)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected outputs (valid between edges) and the values due after the next edge.
  logic [65:0] exp_b0 = '0, exp_b1 = '0, nxt_b0, nxt_b1;
  logic        exp_valid = 1'b0, exp_mis = 1'b0, nxt_valid, nxt_mis;

  // Bytes accepted since the last block boundary, already scrambled if enabled.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         qc[$];

`ifdef LANE_SCRAMBLER_EN
  // Scrambler output history: out[n] = in[n] ^ out[n-39] ^ out[n-58], seeded by SEED.
  bit hist0[$];
  bit hist1[$];

  task automatic scr_reset();
    hist0.delete();
    hist1.delete();
    for (int k = 57; k >= 0; k--) begin
      hist0.push_back(SEED[k]);
      hist1.push_back(SEED[k]);
    end
  endtask

  task automatic scr(input int lane, input logic [7:0] d, output logic [7:0] o);
    bit b;
    for (int i = 0; i < 8; i++) begin
      if (lane == 0) begin
        b = d[i] ^ hist0[hist0.size()-39] ^ hist0[hist0.size()-58];
        hist0.push_back(b);
        void'(hist0.pop_front());
      end else begin
        b = d[i] ^ hist1[hist1.size()-39] ^ hist1[hist1.size()-58];
        hist1.push_back(b);
        void'(hist1.pop_front());
      end
      o[i] = b;
    end
  endtask
`endif

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); qc.delete();
    exp_b0 = '0; exp_b1 = '0; exp_valid = 1'b0; exp_mis = 1'b0;
`ifdef LANE_SCRAMBLER_EN
    scr_reset();
`endif
  endtask

  task automatic model_step(input logic en, input logic [3:0] ds,
                            input logic [7:0] a, input logic [7:0] b);
    logic [7:0] sa, sb;
    nxt_valid = 1'b0; nxt_mis = 1'b0; nxt_b0 = exp_b0; nxt_b1 = exp_b1;
    if (!en) begin
      q0.delete(); q1.delete(); qc.delete();
`ifdef LANE_SCRAMBLER_EN
      scr_reset();
`endif
    end else begin
`ifdef LANE_SCRAMBLER_EN
      scr(0, a, sa);
      scr(1, b, sb);
`else
      sa = a;
      sb = b;
`endif
      q0.push_back(sa); q1.push_back(sb); qc.push_back(ds == 4'h8);
      if (q0.size() == 8) begin
        nxt_b0[1:0] = qc[0] ? 2'b10 : 2'b01;
        nxt_b1[1:0] = nxt_b0[1:0];
        for (int i = 0; i < 8; i++) begin
          nxt_b0[2+8*i +: 8] = q0[i];
          nxt_b1[2+8*i +: 8] = q1[i];
          if (qc[i] != qc[0]) nxt_mis = 1'b1;
        end
        nxt_valid = 1'b1;
        q0.delete(); q1.delete(); qc.delete();
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic en, input logic [3:0] ds,
                       input logic [7:0] a, input logic [7:0] b);
    enable_enc = en; d_sel = ds; lane_0_tx_in = a; lane_1_tx_in = b;
    model_step(en, ds, a, b);
    @(posedge clk);
    exp_b0 = nxt_b0; exp_b1 = nxt_b1; exp_valid = nxt_valid; exp_mis = nxt_mis;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    chk("block_valid",  {65'd0, block_valid},  {65'd0, exp_valid});
    chk("hdr_mismatch", {65'd0, hdr_mismatch}, {65'd0, exp_mis});
    chk("lane_0_block", lane_0_block, exp_b0);
    chk("lane_1_block", lane_1_block, exp_b1);
  end

  initial begin
    model_reset();
    @(negedge clk);
    chk("reset_b0", lane_0_block, 66'd0);
    chk("reset_valid", {65'd0, block_valid}, 66'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Incrementing data bytes
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'h8, 8'(i), 8'(8'h10 + i));
    chk("t1_valid", {65'd0, block_valid}, 66'd1);
    chk("t1_hdr", {64'd0, lane_0_block[1:0]}, 66'd2);
`ifndef LANE_SCRAMBLER_EN
    chk("t1_lane0", lane_0_block, {64'h0706050403020100, 2'b10});
    chk("t1_lane1", lane_1_block, {64'h1716151413121110, 2'b10});
`endif
    cycle(1'b0, 4'h8, 8'h00, 8'h00);
    chk("t1_one_pulse", {65'd0, block_valid}, 66'd0);

    // Ordered-set block
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'h2, 8'(8'hA0 + i), 8'(8'hB0 + i));
    chk("t2_hdr", {64'd0, lane_0_block[1:0]}, 66'd1);
    chk("t2_hdr1", {64'd0, lane_1_block[1:0]}, 66'd1);
    chk("t2_mis", {65'd0, hdr_mismatch}, 66'd0);

    // Class change at byte 5
    for (int i = 0; i < 8; i++) cycle(1'b1, (i < 5) ? 4'h8 : 4'h2, 8'(i), 8'(i));
    chk("t3_hdr", {64'd0, lane_0_block[1:0]}, 66'd2);
    chk("t3_mis", {65'd0, hdr_mismatch}, 66'd1);

    // Partial block discarded by enable drop
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'h8, 8'hEE, 8'hDD);
    cycle(1'b0, 4'h8, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'h8, 8'(8'h40 + i), 8'(8'h50 + i));
    chk("t4_valid", {65'd0, block_valid}, 66'd1);
`ifndef LANE_SCRAMBLER_EN
    chk("t4_lane0", lane_0_block, {64'h4746454443424140, 2'b10});
`endif

    // Enable dropped exactly on the slot-7 byte
    for (int i = 0; i < 7; i++) cycle(1'b1, 4'h8, 8'h11, 8'h22);
    cycle(1'b0, 4'h8, 8'h33, 8'h44);
    chk("t5_no_strobe", {65'd0, block_valid}, 66'd0);

    // Asynchronous reset mid-block
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'h8, 8'h99, 8'h88);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_b0", lane_0_block, 66'd0);
    chk("t6_rst_b1", lane_1_block, 66'd0);
    chk("t6_rst_valid", {65'd0, block_valid}, 66'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) cycle(1'b1, 4'h8, 8'(8'h60 + i), 8'(8'h70 + i));
    chk("t6_no_early", {65'd0, block_valid}, 66'd0);
    cycle(1'b1, 4'h8, 8'h67, 8'h77);
    chk("t6_strobe", {65'd0, block_valid}, 66'd1);

    // Zero payload, twice, then again after a reinit
    cycle(1'b0, 4'h8, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'h8, 8'h00, 8'h00);
    cycle(1'b0, 4'h8, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'h8, 8'h00, 8'h00);
    chk("t7_hdr", {64'd0, lane_0_block[1:0]}, 66'd2);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 19) != 0),
            ($urandom_range(0, 9) < 8) ? 4'h8 : 4'($urandom),
            8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
